// File: rtl/id_ex_pipe_hz.sv
// ID/EX pipeline register with valid tracking, hold, flush and load-use hazard detection.
// A load-use hazard inserts a single bubble into EX and asks PC/IF-ID to stall for that cycle.
module id_ex_pipe_hz #(
    parameter int DATA_W   = 64,
    parameter int PC_W     = 32,
    parameter int IMM_IN_W = 32,
    parameter int ALUCTL_W = 11,
    parameter int RA_W     = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                valid_in,
    input  logic                hold_in,
    input  logic                flush_in,
    input  logic [8:0]          ctrl_in,
    input  logic [RA_W-1:0]     rs_a_in,
    input  logic [RA_W-1:0]     rs_b_in,
    input  logic [DATA_W-1:0]   data_a_in,
    input  logic [DATA_W-1:0]   data_b_in,
    input  logic [PC_W-1:0]     pc_in,
    input  logic [ALUCTL_W-1:0] aluctl_in,
    input  logic [RA_W-1:0]     rd_in,
    input  logic [IMM_IN_W-1:0] imm_in,
    output logic                valid_out,
    output logic [8:0]          ctrl_out,
    output logic [DATA_W-1:0]   data_a_out,
    output logic [DATA_W-1:0]   data_b_out,
    output logic [PC_W-1:0]     pc_out,
    output logic [ALUCTL_W-1:0] aluctl_out,
    output logic [RA_W-1:0]     rd_out,
    output logic [DATA_W-1:0]   imm_out,
    output logic                stall_out,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam logic [RA_W-1:0] ZERO_ADDR = RA_W'(ZERO_REG);

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_IN_W-1:0] raw);
        logic signed [IMM_IN_W-1:0] s;
        s = raw;
        return DATA_W'(s);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic                valid_q,  valid_d;
    logic [8:0]          ctrl_q,   ctrl_d;
    logic [DATA_W-1:0]   data_a_q, data_a_d;
    logic [DATA_W-1:0]   data_b_q, data_b_d;
    logic [PC_W-1:0]     pc_q,     pc_d;
    logic [ALUCTL_W-1:0] aluctl_q, aluctl_d;
    logic [RA_W-1:0]     rd_q,     rd_d;
    logic [DATA_W-1:0]   imm_q,    imm_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                load_use;

    // A bubble in EX has valid_q=0, so a single hazard never stalls twice.
    assign load_use = valid_q & ctrl_q[6] & (rd_q != ZERO_ADDR) & valid_in &
                      ((rd_q == rs_a_in) | (rd_q == rs_b_in));

    assign stall_out = hold_in | (load_use & ~flush_in);

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        pc_d     = pc_q;
        aluctl_d = aluctl_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        cnt_d    = cnt_q;
        if (flush_in || !hold_in) begin
            // Datapath fields load even for bubbles; only valid/ctrl mark the slot dead.
            data_a_d = data_a_in;
            data_b_d = data_b_in;
            pc_d     = pc_in;
            aluctl_d = aluctl_in;
            rd_d     = rd_in;
            imm_d    = sext_imm(imm_in);
            if (flush_in || load_use) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                cnt_d   = sat_inc(cnt_q);
            end else begin
                valid_d = valid_in;
                ctrl_d  = valid_in ? ctrl_in : 9'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            pc_q     <= '0;
            aluctl_q <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            pc_q     <= pc_d;
            aluctl_q <= aluctl_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_out  = valid_q;
    assign ctrl_out   = ctrl_q;
    assign data_a_out = data_a_q;
    assign data_b_out = data_b_q;
    assign pc_out     = pc_q;
    assign aluctl_out = aluctl_q;
    assign rd_out     = rd_q;
    assign imm_out    = imm_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_hz.sv
// Scoreboard bench for id_ex_pipe_hz: directed vectors push hand-computed expectations,
// a monitor pops them and compares stall_out before the edge and the registers after it.
module tb_id_ex_pipe_hz;

    localparam int DATA_W   = 64;
    localparam int PC_W     = 32;
    localparam int IMM_IN_W = 32;
    localparam int ALUCTL_W = 11;
    localparam int RA_W     = 5;
    localparam int CNT_W    = 4;

    localparam logic [8:0] LD  = 9'h0D8;  // aluSrc, memRead, regWrite, mem2reg
    localparam logic [8:0] ADD = 9'h012;  // regWrite, aluOp=10

    logic                CLK = 1'b0;
    logic                RESET, valid_in, hold_in, flush_in;
    logic [8:0]          ctrl_in;
    logic [RA_W-1:0]     rs_a_in, rs_b_in, rd_in;
    logic [DATA_W-1:0]   data_a_in, data_b_in;
    logic [PC_W-1:0]     pc_in;
    logic [ALUCTL_W-1:0] aluctl_in;
    logic [IMM_IN_W-1:0] imm_in;
    logic                valid_out, stall_out;
    logic [8:0]          ctrl_out;
    logic [DATA_W-1:0]   data_a_out, data_b_out, imm_out;
    logic [PC_W-1:0]     pc_out;
    logic [ALUCTL_W-1:0] aluctl_out;
    logic [RA_W-1:0]     rd_out;
    logic [CNT_W-1:0]    bubble_cnt;

    id_ex_pipe_hz #(
        .DATA_W(DATA_W), .PC_W(PC_W), .IMM_IN_W(IMM_IN_W), .ALUCTL_W(ALUCTL_W),
        .RA_W(RA_W), .ZERO_REG(31), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .valid_in(valid_in), .hold_in(hold_in),
        .flush_in(flush_in), .ctrl_in(ctrl_in), .rs_a_in(rs_a_in), .rs_b_in(rs_b_in),
        .data_a_in(data_a_in), .data_b_in(data_b_in), .pc_in(pc_in),
        .aluctl_in(aluctl_in), .rd_in(rd_in), .imm_in(imm_in),
        .valid_out(valid_out), .ctrl_out(ctrl_out), .data_a_out(data_a_out),
        .data_b_out(data_b_out), .pc_out(pc_out), .aluctl_out(aluctl_out),
        .rd_out(rd_out), .imm_out(imm_out), .stall_out(stall_out),
        .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                id;
        bit                chk_stall;
        logic              stall;
        logic              valid;
        logic [8:0]        ctrl;
        logic [DATA_W-1:0] a;
        logic [RA_W-1:0]   rd;
        logic [DATA_W-1:0] imm;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    task automatic chk(input string name, input int id, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h exp=%h", name, id, got, exp);
        end
    endtask

    // Side data is derived from data_a so it travels through hold/bubble/reset the same way:
    // data_b=~a, pc=a[31:0], aluctl=a[10:0]; an expected a of zero means everything cleared.
    task automatic vec(input logic rst, input logic v, input logic h, input logic f,
                       input logic [8:0] ctrl, input logic [RA_W-1:0] rsa,
                       input logic [RA_W-1:0] rsb, input logic [DATA_W-1:0] da,
                       input logic [RA_W-1:0] rd, input logic [IMM_IN_W-1:0] imm,
                       input bit cs, input logic e_stall, input logic e_v,
                       input logic [8:0] e_ctrl, input logic [DATA_W-1:0] e_a,
                       input logic [RA_W-1:0] e_rd, input logic [DATA_W-1:0] e_imm,
                       input logic [CNT_W-1:0] e_cnt);
        exp_t e;
        @(negedge CLK);
        RESET = rst; valid_in = v; hold_in = h; flush_in = f; ctrl_in = ctrl;
        rs_a_in = rsa; rs_b_in = rsb; data_a_in = da; data_b_in = ~da;
        pc_in = da[PC_W-1:0]; aluctl_in = da[ALUCTL_W-1:0]; rd_in = rd; imm_in = imm;
        vec_id++;
        e.id = vec_id; e.chk_stall = cs; e.stall = e_stall; e.valid = e_v; e.ctrl = e_ctrl;
        e.a = e_a; e.rd = e_rd; e.imm = e_imm; e.cnt = e_cnt;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [DATA_W-1:0] eb;
        forever begin
            @(negedge CLK);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_stall) chk("stall_out", e.id, 64'(stall_out), 64'(e.stall));
                @(posedge CLK);
                #1;
                eb = (e.a == '0) ? '0 : ~e.a;
                chk("valid_out", e.id, 64'(valid_out), 64'(e.valid));
                chk("ctrl_out", e.id, 64'(ctrl_out), 64'(e.ctrl));
                chk("data_a_out", e.id, data_a_out, e.a);
                chk("data_b_out", e.id, data_b_out, eb);
                chk("pc_out", e.id, 64'(pc_out), 64'(e.a[PC_W-1:0]));
                chk("aluctl_out", e.id, 64'(aluctl_out), 64'(e.a[ALUCTL_W-1:0]));
                chk("rd_out", e.id, 64'(rd_out), 64'(e.rd));
                chk("imm_out", e.id, imm_out, e.imm);
                chk("bubble_cnt", e.id, 64'(bubble_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin : driver
        int guard;
        logic [CNT_W-1:0] ec;
        // Reset for two cycles with live inputs; state is unknown before the first edge.
        vec(1, 1, 0, 0, LD,  1, 2, 64'h1234, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 1, 1, 1, ADD, 3, 3, 64'h5678, 9, 32'h66, 1, 1, 0, 0, 0, 0, 0, 0);
        // Load X3 then ADD using X3: one stall, bubble, then ADD enters.
        vec(0, 1, 0, 0, LD,  1, 2, 64'h1111, 3, 32'h10, 1, 0, 1, LD, 64'h1111, 3, 64'h10, 0);
        vec(0, 1, 0, 0, ADD, 3, 4, 64'h2222, 5, 32'h0,  1, 1, 0, 0,  64'h2222, 5, 64'h0, 1);
        vec(0, 1, 0, 0, ADD, 3, 4, 64'h2222, 5, 32'h0,  1, 0, 1, ADD, 64'h2222, 5, 64'h0, 1);
        // Load into XZR then use X31: no hazard. Immediate sign extension both polarities.
        vec(0, 1, 0, 0, LD, 1, 2, 64'h3333, 31, 32'hFFFF_FFF0, 1, 0, 1, LD, 64'h3333, 31,
            64'hFFFF_FFFF_FFFF_FFF0, 1);
        vec(0, 1, 0, 0, ADD, 31, 31, 64'h4444, 6, 32'h7, 1, 0, 1, ADD, 64'h4444, 6, 64'h7, 1);
        // Load X7, then three held cycles with changing inputs, then hold+flush.
        vec(0, 1, 0, 0, LD,  1, 2, 64'h5555, 7,  32'h8, 1, 0, 1, LD, 64'h5555, 7, 64'h8, 1);
        vec(0, 1, 1, 0, ADD, 0, 7, 64'h6666, 8,  32'h9, 1, 1, 1, LD, 64'h5555, 7, 64'h8, 1);
        vec(0, 1, 1, 0, ADD, 0, 0, 64'h7777, 9,  32'hA, 1, 1, 1, LD, 64'h5555, 7, 64'h8, 1);
        vec(0, 0, 1, 0, LD,  7, 0, 64'h8888, 10, 32'hB, 1, 1, 1, LD, 64'h5555, 7, 64'h8, 1);
        vec(0, 1, 1, 1, ADD, 7, 0, 64'h9999, 11, 32'h1, 1, 1, 0, 0, 64'h9999, 11, 64'h1, 2);
        // Invalid slot loads with ctrl zero and is not counted.
        vec(0, 0, 0, 0, LD,  1, 2, 64'hAAAA, 12, 32'h2, 1, 0, 0, 0, 64'hAAAA, 12, 64'h2, 2);
        // Load-use coinciding with flush: no stall, one bubble counted.
        vec(0, 1, 0, 0, LD,  1, 2, 64'hBBBB, 13, 32'h3, 1, 0, 1, LD, 64'hBBBB, 13, 64'h3, 2);
        vec(0, 1, 0, 1, ADD, 13, 0, 64'hCCCC, 14, 32'h4, 1, 0, 0, 0, 64'hCCCC, 14, 64'h4, 3);
        // Matching address but invalid decode slot: no hazard.
        vec(0, 1, 0, 0, LD,  1, 2, 64'hDDDD, 15, 32'h5, 1, 0, 1, LD, 64'hDDDD, 15, 64'h5, 3);
        vec(0, 0, 0, 0, ADD, 15, 15, 64'hEEEE, 16, 32'h6, 1, 0, 0, 0, 64'hEEEE, 16, 64'h6, 3);
        // Twenty flushes: counter climbs from 3 and sticks at 4'hF.
        for (int i = 0; i < 20; i++) begin
            ec = (3 + i + 1 > 15) ? 4'hF : CNT_W'(3 + i + 1);
            vec(0, 1, 0, 1, ADD, 0, 0, 64'hF000 + 64'(i), 17, 32'h0, 1, 0, 0, 0,
                64'hF000 + 64'(i), 17, 64'h0, ec);
        end
        // Final reset clears the saturated counter.
        vec(1, 1, 0, 0, LD, 1, 2, 64'h1357, 3, 32'h9, 1, 0, 0, 0, 0, 0, 0, 0);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        repeat (2) @(negedge CLK);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
